// File: rtl/ysyx_22040632_mdu_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22040632_RISCV_PKG
// Shared types for the EXU.
//   func           : EXU operation selector. The MDU services mul, mulw, divw,
//                    divuw, remw and remuw; the ALU codes are not its business.
//   mdu_state      : sequencing states of the iterative multiply/divide unit.
//   MDU_W_ITERS    : iteration count for 32-bit (W) operations.
//   MDU_D_ITERS    : iteration count for the full 64-bit multiply.
//   sext32()       : sign-extend a 32-bit value to 64 bits.
// ----------------------------------------------------------------------------
package ysyx_22040632_RISCV_PKG;

    typedef enum logic [3:0] {
        alu_add,
        alu_sub,
        mul,
        mulw,
        divw,
        divuw,
        remw,
        remuw
    } func;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_CALC,
        MDU_FIX,
        MDU_DONE
    } mdu_state;

    localparam logic [6:0] MDU_W_ITERS = 7'd32;
    localparam logic [6:0] MDU_D_ITERS = 7'd64;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22040632_mdu_div_iter.sv
// ----------------------------------------------------------------------------
// ysyx_22040632_div_iter
// One combinational restoring-division step on a 32-bit {remainder, quotient}
// shift register. The dividend is shifted in from the quotient MSB; the new
// quotient bit enters at the LSB.
//   i_rem [31:0] : partial remainder (always < divisor)
//   i_quo [31:0] : partial quotient / remaining dividend bits
//   i_div [31:0] : divisor (unsigned magnitude)
//   o_rem [31:0] : next partial remainder
//   o_quo [31:0] : next partial quotient
// ----------------------------------------------------------------------------
module ysyx_22040632_div_iter (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quo,
    input  logic [31:0] i_div,
    output logic [31:0] o_rem,
    output logic [31:0] o_quo
);

    logic [32:0] w_top;
    logic [31:0] w_diff;
    logic        w_ge;

    assign w_top  = {i_rem, i_quo[31]};
    // When w_top[32] is set the shifted remainder exceeds any 32-bit divisor,
    // and the true difference still fits in 32 bits, so the wrapped
    // subtraction below is exact.
    assign w_diff = w_top[31:0] - i_div;
    assign w_ge   = w_top[32] | (w_top[31:0] >= i_div);

    assign o_rem  = w_ge ? w_diff : w_top[31:0];
    assign o_quo  = {i_quo[30:0], w_ge};

endmodule

// File: rtl/ysyx_22040632_mdu.sv
// ----------------------------------------------------------------------------
// ysyx_22040632_mdu
// Iterative multiply/divide unit beside the ALU. Accepts one M-extension op
// through in_valid/in_ready, iterates one bit per cycle, applies sign fix-up
// and W sign extension, and holds the result until out_ready.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : request handshake (in_ready only in IDLE, not flush)
//   op, src1, src2      : operation and operands
//   flush               : abandon any operation, back to IDLE next edge
//   out_valid/out_ready : result handshake
//   result              : result, stable while out_valid
//   busy                : state is not IDLE
// The first iteration is performed on the accept edge itself, so the counter
// (loaded with N) reaching 1 marks the last of N iterations.
// ----------------------------------------------------------------------------
module ysyx_22040632_mdu
    import ysyx_22040632_RISCV_PKG::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  func             op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    mdu_state        r_state;
    mdu_state        w_state_next;
    func             r_op;
    logic [6:0]      r_cnt;
    // r_a: product accumulator / partial remainder
    // r_b: multiplicand / divisor magnitude
    // r_c: multiplier / quotient shift register
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_c;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_result;

    // ---------------- incoming operation decode ----------------
    logic            w_accept;
    logic            w_in_mul;
    logic            w_in_div;
    logic            w_in_signed;
    logic            w_in_rem;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_result;
    logic [31:0]     w_mag1;
    logic [31:0]     w_mag2;
    logic [XLEN-1:0] w_prep_b;
    logic [XLEN-1:0] w_prep_c;

    assign in_ready    = (r_state == MDU_IDLE) && !flush;
    assign w_accept    = in_valid && in_ready;

    assign w_in_mul    = (op == mul) || (op == mulw);
    assign w_in_div    = (op == divw) || (op == divuw) || (op == remw) || (op == remuw);
    assign w_in_signed = (op == divw) || (op == remw);
    assign w_in_rem    = (op == remw) || (op == remuw);
    assign w_div_zero  = (src2[31:0] == 32'd0);
    assign w_ovf       = w_in_signed && (src1[31:0] == 32'h8000_0000)
                                     && (src2[31:0] == 32'hFFFF_FFFF);
    // Anything that is neither a multiply nor a regular division completes on
    // the accept edge with a precomputed result.
    assign w_special   = !w_in_mul && (!w_in_div || w_div_zero || w_ovf);

    always_comb begin
        w_special_result = '0;
        if (w_in_div) begin
            if (w_div_zero) begin
                w_special_result = w_in_rem ? sext32(src1[31:0]) : {XLEN{1'b1}};
            end else if (w_ovf) begin
                w_special_result = w_in_rem ? '0 : 64'hFFFF_FFFF_8000_0000;
            end
        end
    end

    assign w_mag1 = (w_in_signed && src1[31]) ? (32'd0 - src1[31:0]) : src1[31:0];
    assign w_mag2 = (w_in_signed && src2[31]) ? (32'd0 - src2[31:0]) : src2[31:0];

    always_comb begin
        w_prep_b = {32'd0, w_mag2};
        w_prep_c = {32'd0, w_mag1};
        if (op == mul) begin
            w_prep_b = src1;
            w_prep_c = src2;
        end else if (op == mulw) begin
            w_prep_b = {32'd0, src1[31:0]};
            w_prep_c = {32'd0, src2[31:0]};
        end
    end

    // ---------------- shared iteration datapath ----------------
    logic            w_r_mul;
    logic            w_cur_mul;
    logic [XLEN-1:0] w_cur_a;
    logic [XLEN-1:0] w_cur_b;
    logic [XLEN-1:0] w_cur_c;
    logic [XLEN-1:0] w_mul_a;
    logic [31:0]     w_div_rem;
    logic [31:0]     w_div_quo;
    logic [XLEN-1:0] w_step_a;
    logic [XLEN-1:0] w_step_b;
    logic [XLEN-1:0] w_step_c;

    assign w_r_mul   = (r_op == mul) || (r_op == mulw);
    // In IDLE the step operates on freshly prepared operands (accept edge);
    // otherwise it continues from the registered state.
    assign w_cur_mul = (r_state == MDU_IDLE) ? w_in_mul : w_r_mul;
    assign w_cur_a   = (r_state == MDU_IDLE) ? '0       : r_a;
    assign w_cur_b   = (r_state == MDU_IDLE) ? w_prep_b : r_b;
    assign w_cur_c   = (r_state == MDU_IDLE) ? w_prep_c : r_c;

    assign w_mul_a   = w_cur_a + (w_cur_c[0] ? w_cur_b : '0);

    ysyx_22040632_div_iter u_div_iter (
        .i_rem (w_cur_a[31:0]),
        .i_quo (w_cur_c[31:0]),
        .i_div (w_cur_b[31:0]),
        .o_rem (w_div_rem),
        .o_quo (w_div_quo)
    );

    assign w_step_a = w_cur_mul ? w_mul_a          : {32'd0, w_div_rem};
    assign w_step_b = w_cur_mul ? (w_cur_b << 1)   : w_cur_b;
    assign w_step_c = w_cur_mul ? (w_cur_c >> 1)   : {32'd0, w_div_quo};

    // ---------------- sign fix-up ----------------
    logic [XLEN-1:0] w_fix_result;

    always_comb begin
        w_fix_result = '0;
        case (r_op)
            mul:         w_fix_result = r_a;
            mulw:        w_fix_result = sext32(r_a[31:0]);
            divw, divuw: w_fix_result = sext32(r_neg_q ? (32'd0 - r_c[31:0]) : r_c[31:0]);
            remw, remuw: w_fix_result = sext32(r_neg_r ? (32'd0 - r_a[31:0]) : r_a[31:0]);
            default:     w_fix_result = '0;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MDU_IDLE: if (w_accept) w_state_next = w_special ? MDU_DONE : MDU_CALC;
            // This edge takes the counter from 2 to 1: last iteration.
            MDU_CALC: if (r_cnt == 7'd2) w_state_next = MDU_FIX;
            MDU_FIX:  w_state_next = MDU_DONE;
            MDU_DONE: if (out_ready) w_state_next = MDU_IDLE;
            default:  w_state_next = MDU_IDLE;
        endcase
        if (flush) begin
            w_state_next = MDU_IDLE;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= alu_add;
            r_cnt    <= 7'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            if (r_state == MDU_IDLE && w_accept) begin
                r_op    <= op;
                r_cnt   <= (op == mul) ? MDU_D_ITERS : MDU_W_ITERS;
                r_a     <= w_step_a;
                r_b     <= w_step_b;
                r_c     <= w_step_c;
                r_neg_q <= w_in_signed && (src1[31] ^ src2[31]);
                r_neg_r <= w_in_signed && src1[31];
                if (w_special) begin
                    r_result <= w_special_result;
                end
            end else if (r_state == MDU_CALC && !flush) begin
                r_cnt <= r_cnt - 7'd1;
                r_a   <= w_step_a;
                r_b   <= w_step_b;
                r_c   <= w_step_c;
            end else if (r_state == MDU_FIX && !flush) begin
                r_result <= w_fix_result;
            end
        end
    end

    assign out_valid = (r_state == MDU_DONE);
    assign busy      = (r_state != MDU_IDLE);
    assign result    = r_result;

endmodule

// File: tb/tb_ysyx_22040632_mdu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22040632_mdu
// Self-checking bench for the iterative multiply/divide unit. Expected results
// come from plain SystemVerilog arithmetic on the RISC-V rules; expected
// latencies from the per-op cycle counts.
// ----------------------------------------------------------------------------
module tb_ysyx_22040632_mdu;
    import ysyx_22040632_RISCV_PKG::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    func         op = alu_add;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ysyx_22040632_mdu #(.XLEN(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_result(input func f, input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, t;
        int sa, sb;
        a32 = a[31:0];
        b32 = b[31:0];
        sa  = $signed(a32);
        sb  = $signed(b32);
        case (f)
            mul:  return a * b;
            mulw: begin t = a32 * b32; return {{32{t[31]}}, t}; end
            divw: begin
                if (b32 == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
                if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) t = a32;
                else t = sa / sb;
                return {{32{t[31]}}, t};
            end
            divuw: begin
                if (b32 == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
                t = a32 / b32;
                return {{32{t[31]}}, t};
            end
            remw: begin
                if (b32 == 0) return {{32{a32[31]}}, a32};
                if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return 64'd0;
                t = sa % sb;
                return {{32{t[31]}}, t};
            end
            remuw: begin
                if (b32 == 0) return {{32{a32[31]}}, a32};
                t = a32 % b32;
                return {{32{t[31]}}, t};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic int ref_latency(input func f, input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32;
        a32 = a[31:0];
        b32 = b[31:0];
        case (f)
            mul:  return 65;
            mulw: return 33;
            divw, remw: begin
                if (b32 == 0) return 1;
                if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return 1;
                return 33;
            end
            divuw, remuw: return (b32 == 0) ? 1 : 33;
            default: return 1;
        endcase
    endfunction

    // ---------------- transaction driver ----------------
    // Issues one op with out_ready high, returns the result, the latency
    // (1 = out_valid in the cycle right after the accept edge), whether busy
    // stayed high, in_ready just after accept, and in_ready after the handshake.
    task automatic run_op(input func f, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat, output bit busy_ok,
                          output bit rdy_busy, output bit rdy_after, output bit timeout);
        @(negedge clk);
        op = f; src1 = a; src2 = b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; busy_ok = 1'b1; timeout = 1'b0; rdy_busy = in_ready;
        while (!out_valid) begin
            if (!busy) busy_ok = 1'b0;
            if (lat >= 200) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
        res = result;
        @(posedge clk); #1;
        rdy_after = in_ready && !out_valid;
        $display("op %-6s src1 %h src2 %h result %h latency %0d", f.name(), a, b, res, lat);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++;
        if (result !== 64'd0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    endtask

    task automatic test_directed();
        func         f[10];
        logic [63:0] a[10], b[10], e[10];
        int          l[10];
        logic [63:0] res;
        int          lat;
        bit          bok, rb, ra, to;
        f[0] = mulw;   a[0] = 64'h7FFF_FFFF;            b[0] = 64'd2;                    e[0] = 64'hFFFF_FFFF_FFFF_FFFE; l[0] = 33;
        f[1] = mul;    a[1] = 64'hFFFF_FFFF_FFFF_FFFF;  b[1] = 64'd3;                    e[1] = 64'hFFFF_FFFF_FFFF_FFFD; l[1] = 65;
        f[2] = divw;   a[2] = 64'hFFFF_FFFF_FFFF_FFF9;  b[2] = 64'd2;                    e[2] = 64'hFFFF_FFFF_FFFF_FFFD; l[2] = 33;
        f[3] = remw;   a[3] = 64'hFFFF_FFFF_FFFF_FFF9;  b[3] = 64'd2;                    e[3] = 64'hFFFF_FFFF_FFFF_FFFF; l[3] = 33;
        f[4] = divuw;  a[4] = 64'hFFFF_FFFF;            b[4] = 64'd2;                    e[4] = 64'h0000_0000_7FFF_FFFF; l[4] = 33;
        f[5] = divuw;  a[5] = 64'd5;                    b[5] = 64'd0;                    e[5] = 64'hFFFF_FFFF_FFFF_FFFF; l[5] = 1;
        f[6] = remuw;  a[6] = 64'd5;                    b[6] = 64'd0;                    e[6] = 64'd5;                   l[6] = 1;
        f[7] = divw;   a[7] = 64'h8000_0000;            b[7] = 64'hFFFF_FFFF;            e[7] = 64'hFFFF_FFFF_8000_0000; l[7] = 1;
        f[8] = remw;   a[8] = 64'h8000_0000;            b[8] = 64'hFFFF_FFFF;            e[8] = 64'd0;                   l[8] = 1;
        f[9] = alu_sub; a[9] = 64'd9;                   b[9] = 64'd4;                    e[9] = 64'd0;                   l[9] = 1;
        for (int i = 0; i < 10; i++) begin
            run_op(f[i], a[i], b[i], res, lat, bok, rb, ra, to);
            checks++;
            if (to) begin errors++; $display("FAIL dir_timeout idx %0d got no out_valid exp out_valid", i); end
            checks++;
            if (res !== e[i]) begin errors++; $display("FAIL dir_result idx %0d got %h exp %h", i, res, e[i]); end
            checks++;
            if (lat != l[i]) begin errors++; $display("FAIL dir_latency idx %0d got %0d exp %0d", i, lat, l[i]); end
            checks++;
            if (!bok) begin errors++; $display("FAIL dir_busy idx %0d got 0 exp 1", i); end
        end
    endtask

    task automatic test_random();
        func         f;
        logic [63:0] a, b, res, e;
        int          lat, el;
        bit          bok, rb, ra, to;
        for (int i = 0; i < 40; i++) begin
            f = func'($urandom_range(0, 7));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b[31:0] = 32'd0;
                1: begin a[31:0] = 32'h8000_0000; b[31:0] = 32'hFFFF_FFFF; end
                2: b[31:0] = $urandom_range(1, 20);
                default: ;
            endcase
            e  = ref_result(f, a, b);
            el = ref_latency(f, a, b);
            run_op(f, a, b, res, lat, bok, rb, ra, to);
            checks++;
            if (res !== e) begin errors++; $display("FAIL rand_result %0d op %s got %h exp %h", i, f.name(), res, e); end
            checks++;
            if (lat != el) begin errors++; $display("FAIL rand_latency %0d op %s got %0d exp %0d", i, f.name(), lat, el); end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        int          lat;
        bit          bok, rb, ra, to;
        for (int i = 0; i < 4; i++) begin
            run_op((i % 2 == 0) ? remuw : mulw, 64'd1000 + i, 64'd7, res, lat, bok, rb, ra, to);
            checks++;
            if (rb !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy %0d got %b exp 0", i, rb); end
            checks++;
            if (ra !== 1'b1) begin errors++; $display("FAIL b2b_ready_after %0d got %b exp 1", i, ra); end
        end
    endtask

    task automatic test_back_pressure();
        int n;
        @(negedge clk);
        op = divw; src1 = 64'd100; src2 = 64'd7; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!out_valid) begin errors++; $display("FAIL bp_timeout got 0 exp out_valid 1"); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 64'd14) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid %b result %h exp valid 1 result %h", i, out_valid, result, 64'd14);
            end
        end
        $display("op divw   src1 %h src2 %h result %h held 5 cycles", 64'd100, 64'd7, result);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got in_ready %b out_valid %b exp 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_flush();
        bit          seen;
        logic [63:0] res;
        int          lat;
        bit          bok, rb, ra, to;
        @(negedge clk);
        op = divw; src1 = 64'd12345; src2 = 64'd17; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle got busy %b out_valid %b exp 0 0", busy, out_valid);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL flush_no_result got out_valid 1 exp 0"); end
        $display("op divw   flushed in CALC, no result delivered");
        // flush together with in_valid in IDLE: nothing is accepted
        @(negedge clk);
        op = mulw; src1 = 64'd9; src2 = 64'd9; in_valid = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_accept_ready got %b exp 0", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_accept_busy got %b exp 0", busy); end
        run_op(mulw, 64'd3, 64'd4, res, lat, bok, rb, ra, to);
        checks++;
        if (res !== 64'd12 || lat != 33) begin
            errors++;
            $display("FAIL flush_recover got result %h latency %0d exp %h 33", res, lat, 64'd12);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int          lat;
        bit          bok, rb, ra, to;
        @(negedge clk);
        op = mul; src1 = 64'h1234_5678_9ABC_DEF0; src2 = 64'd77; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid got in_ready %b out_valid %b busy %b result %h exp 1 0 0 0",
                     in_ready, out_valid, busy, result);
        end
        $display("op mul    reset asserted mid-operation");
        @(negedge clk);
        rst = 1'b0;
        run_op(mulw, 64'd5, 64'd6, res, lat, bok, rb, ra, to);
        checks++;
        if (res !== 64'd30) begin errors++; $display("FAIL reset_recover got %h exp %h", res, 64'd30); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_directed();
        test_random();
        test_back_to_back();
        test_back_pressure();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
